// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the adder block.
// Ports (signals): i_augend, i_addend, i_carry, i_valid toward the adder;
//   o_sum, o_carry (combinational) and o_sum_q, o_carry_q, o_valid
//   (registered) back from it. When ADDER_OVERFLOW_EN is defined the bundle
//   also carries o_overflow and o_overflow_q.
// master: the side that supplies operands. slave: the adder itself.
interface adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_augend;
  logic [WIDTH-1:0] i_addend;
  logic             i_carry;
  logic             i_valid;

  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic [WIDTH-1:0] o_sum_q;
  logic             o_carry_q;
  logic             o_valid;
`ifdef ADDER_OVERFLOW_EN
  logic             o_overflow;
  logic             o_overflow_q;
`endif

  modport master (
    output i_augend,
    output i_addend,
    output i_carry,
    output i_valid,
    input  o_sum,
    input  o_carry,
    input  o_sum_q,
    input  o_carry_q,
    input  o_valid
`ifdef ADDER_OVERFLOW_EN
    ,
    input  o_overflow,
    input  o_overflow_q
`endif
  );

  modport slave (
    input  i_augend,
    input  i_addend,
    input  i_carry,
    input  i_valid,
    output o_sum,
    output o_carry,
    output o_sum_q,
    output o_carry_q,
    output o_valid
`ifdef ADDER_OVERFLOW_EN
    ,
    output o_overflow,
    output o_overflow_q
`endif
  );
endinterface

// File: rtl/adder.sv
// adder: WIDTH-bit unsigned ripple-carry adder, {carry, sum} = a + b + cin.
// Ports: i_clock, i_reset (async, active-high), bus (adder_if.slave) holding
//   operands, carry-in, valid, combinational result and a 1-cycle registered
//   copy of the result with a valid flag.
// Optional: define ADDER_OVERFLOW_EN to add signed-overflow outputs
//   o_overflow / o_overflow_q. Latency: 0 (o_sum/o_carry), 1 (registered).
// No backpressure: a new operand pair may be presented every cycle.
module adder #(
  parameter int WIDTH = 8   // legal range 1..64; must match the bus WIDTH
) (
  input  logic  i_clock,
  input  logic  i_reset,
  adder_if.slave bus
);

  // -------------------------------------------------------------------------
  // Combinational ripple-carry chain.
  // Each bit is a full adder: s = a ^ b ^ cin, cout = (a & b) | (cin & (a^b)).
  // The chain is walked in a loop with a running carry variable rather than
  // a carry vector, so the tools see a single acyclic block.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_c;
  logic             carry_c;
  logic             prop;
`ifdef ADDER_OVERFLOW_EN
  logic             carry_into_msb;
`endif

  always_comb begin
    sum_c   = '0;
    carry_c = bus.i_carry;
    prop    = 1'b0;
`ifdef ADDER_OVERFLOW_EN
    carry_into_msb = bus.i_carry;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      prop = bus.i_augend[i] ^ bus.i_addend[i];
`ifdef ADDER_OVERFLOW_EN
      // Remember the carry entering the top bit for the signed-overflow test.
      if (i == WIDTH - 1) begin
        carry_into_msb = carry_c;
      end
`endif
      sum_c[i] = prop ^ carry_c;
      carry_c  = (bus.i_augend[i] & bus.i_addend[i]) | (carry_c & prop);
    end
  end

  assign bus.o_sum   = sum_c;
  assign bus.o_carry = carry_c;

`ifdef ADDER_OVERFLOW_EN
  // Two's-complement overflow: carry into MSB differs from carry out of MSB.
  logic overflow_c;
  assign overflow_c     = carry_into_msb ^ carry_c;
  assign bus.o_overflow = overflow_c;
`endif

  // -------------------------------------------------------------------------
  // Registered copy. Valid always follows the input valid; the data registers
  // only load on valid so the last accepted result stays visible.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        sum_q   <= sum_c;
        carry_q <= carry_c;
      end
    end
  end

  assign bus.o_sum_q   = sum_q;
  assign bus.o_carry_q = carry_q;
  assign bus.o_valid   = valid_q;

`ifdef ADDER_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
    end else if (bus.i_valid) begin
      overflow_q <= overflow_c;
    end
  end

  assign bus.o_overflow_q = overflow_q;
`endif

endmodule

// File: tb/tb_adder.sv
// tb_adder: checks adder at WIDTH 1, 8 and 16 with stimulus tables,
// hand-written latency/reset sequences and a random run against a plain
// arithmetic reference model.
module tb_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_if #(.WIDTH(1))  if1 ();
  adder_if #(.WIDTH(8))  if8 ();
  adder_if #(.WIDTH(16)) if16 ();

  adder #(.WIDTH(1))  dut1  (.i_clock(clk), .i_reset(rst), .bus(if1));
  adder #(.WIDTH(8))  dut8  (.i_clock(clk), .i_reset(rst), .bus(if8));
  adder #(.WIDTH(16)) dut16 (.i_clock(clk), .i_reset(rst), .bus(if16));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {carry, sum}
  } vec_t;

  vec_t w1_tab [4];
  vec_t w8_tab [3];

  // Reference state for the random WIDTH=16 run.
  logic [16:0] ref_full;
  logic [16:0] ref_q;
  logic        ref_v;
  logic [16:0] pend;
  logic        pend_v;
  logic [15:0] ra, rb;
  logic        rc, rv;

  initial begin
    // Half-adder truth table at WIDTH=1, carry-in 0.
    w1_tab[0] = '{8'd0, 8'd0, 1'b0, 9'd0};
    w1_tab[1] = '{8'd0, 8'd1, 1'b0, 9'd1};
    w1_tab[2] = '{8'd1, 8'd0, 1'b0, 9'd1};
    w1_tab[3] = '{8'd1, 8'd1, 1'b0, 9'd2};
    // WIDTH=8 boundaries.
    w8_tab[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    w8_tab[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    w8_tab[2] = '{8'h00, 8'h00, 1'b1, 9'h001};

    if1.i_augend = '0; if1.i_addend = '0; if1.i_carry = 0; if1.i_valid = 0;
    if8.i_augend = '0; if8.i_addend = '0; if8.i_carry = 0; if8.i_valid = 0;
    if16.i_augend = '0; if16.i_addend = '0; if16.i_carry = 0; if16.i_valid = 0;

    // Reset asserted before any clock edge clears the registers at once.
    #1 rst = 1'b1;
    #1;
    check("rst_sum_q8",   64'(if8.o_sum_q),   64'h0);
    check("rst_carry_q8", 64'(if8.o_carry_q), 64'h0);
    check("rst_valid8",   64'(if8.o_valid),   64'h0);
    check("rst_valid16",  64'(if16.o_valid),  64'h0);

    // Combinational tables; checked 1 time unit after each change.
    for (int i = 0; i < 4; i++) begin
      if1.i_augend = w1_tab[i].a[0];
      if1.i_addend = w1_tab[i].b[0];
      if1.i_carry  = w1_tab[i].cin;
      #1;
      check($sformatf("w1_vec%0d", i), 64'({if1.o_carry, if1.o_sum}),
            64'(w1_tab[i].exp));
    end
    for (int i = 0; i < 3; i++) begin
      if8.i_augend = w8_tab[i].a;
      if8.i_addend = w8_tab[i].b;
      if8.i_carry  = w8_tab[i].cin;
      #1;
      check($sformatf("w8_vec%0d", i), 64'({if8.o_carry, if8.o_sum}),
            64'(w8_tab[i].exp));
    end

    @(negedge clk);
    rst = 1'b0;

    // Registered latency and hold.
    if8.i_augend = 8'h12; if8.i_addend = 8'h34; if8.i_carry = 0; if8.i_valid = 1;
    @(posedge clk); #1;
    check("lat_sum_q",  64'(if8.o_sum_q), 64'h46);
    check("lat_valid",  64'(if8.o_valid), 64'h1);
    if8.i_valid = 0; if8.i_augend = 8'h55;
    @(posedge clk); #1;
    check("hold_sum_q", 64'(if8.o_sum_q), 64'h46);
    check("hold_valid", 64'(if8.o_valid), 64'h0);
    check("hold_comb",  64'({if8.o_carry, if8.o_sum}), 64'h89);

    // Re-load, then reset between edges.
    if8.i_augend = 8'h12; if8.i_valid = 1;
    @(posedge clk); #2;
    check("pre_rst_valid", 64'(if8.o_valid), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_sum_q",   64'(if8.o_sum_q),   64'h0);
    check("arst_carry_q", 64'(if8.o_carry_q), 64'h0);
    check("arst_valid",   64'(if8.o_valid),   64'h0);
    if8.i_augend = 8'h01;
    #1;
    check("arst_comb_live", 64'({if8.o_carry, if8.o_sum}), 64'h35);
    // Valid during reset must not capture.
    @(posedge clk); #1;
    check("rst_edge_valid", 64'(if8.o_valid), 64'h0);
    check("rst_edge_sum_q", 64'(if8.o_sum_q), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    if8.i_augend = 8'hFF; if8.i_addend = 8'h01; if8.i_carry = 0;
    @(posedge clk); #1;
    check("post_rst_sum_q",   64'(if8.o_sum_q),   64'h00);
    check("post_rst_carry_q", 64'(if8.o_carry_q), 64'h1);
    check("post_rst_valid",   64'(if8.o_valid),   64'h1);
    if8.i_valid = 0;

`ifdef ADDER_OVERFLOW_EN
    if8.i_augend = 8'h7F; if8.i_addend = 8'h01; if8.i_carry = 0;
    #1;
    check("ovf_7f_01", 64'(if8.o_overflow), 64'h1);
    if8.i_augend = 8'h80; if8.i_addend = 8'hFF;
    #1;
    check("ovf_80_ff",   64'(if8.o_overflow), 64'h1);
    check("ovf_80_ff_c", 64'(if8.o_carry),    64'h1);
    if8.i_augend = 8'h40; if8.i_addend = 8'h20;
    #1;
    check("ovf_40_20", 64'(if8.o_overflow), 64'h0);
    if1.i_augend = 1'b1; if1.i_addend = 1'b1; if1.i_carry = 0;
    #1;
    check("ovf_w1_11", 64'(if1.o_overflow), 64'h1);
    if1.i_addend = 1'b0;
    #1;
    check("ovf_w1_10", 64'(if1.o_overflow), 64'h0);
    if8.i_augend = 8'h7F; if8.i_addend = 8'h01; if8.i_valid = 1;
    @(posedge clk); #1;
    check("ovf_q_load", 64'(if8.o_overflow_q), 64'h1);
    if8.i_augend = 8'h40; if8.i_addend = 8'h20; if8.i_valid = 0;
    @(posedge clk); #1;
    check("ovf_q_hold", 64'(if8.o_overflow_q), 64'h1);
`endif

    // Random WIDTH=16 run against plain 17-bit arithmetic.
    ref_q = '0;
    ref_v = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 50 == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      rc = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      if16.i_augend = ra; if16.i_addend = rb; if16.i_carry = rc; if16.i_valid = rv;
      #1;
      ref_full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      check("rnd_comb", 64'({if16.o_carry, if16.o_sum}), 64'(ref_full));
      pend   = ref_full;
      pend_v = rv;
      @(posedge clk); #1;
      if (pend_v) ref_q = pend;
      ref_v = pend_v;
      check("rnd_reg",   64'({if16.o_carry_q, if16.o_sum_q}), 64'(ref_q));
      check("rnd_valid", 64'(if16.o_valid), 64'(ref_v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
